// File: rtl/regfile_dump.sv
// +----------------------------------------------------------------------------+
// | Module   : regfile_dump                                                    |
// | Purpose  : Sequences the register-file read port over R0..NUM_REGS-1 and   |
// |            streams each value as a tagged word over valid/ready.           |
// |            Optional checksum word: define REGFILE_DUMP_CHECKSUM_EN.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_dump #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] SR,
  input  logic [DATA_W-1:0] SR_DATA,
  output logic [DATA_W-1:0] Out_Data,
  output logic [ADDR_W-1:0] Out_Idx,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Out_Last,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_SEND = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              w_hs;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  // The read select simply follows the walk index; it is only consumed in ADDR.
  assign SR   = r_idx;
  assign w_hs = Out_Valid & Out_Ready;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      Out_Data  <= '0;
      Out_Idx   <= '0;
      Out_Valid <= 1'b0;
      Out_Last  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_idx   <= '0;
            Busy    <= 1'b1;
            r_state <= S_ADDR;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end

        S_ADDR: begin
          Out_Data  <= SR_DATA;
          Out_Idx   <= r_idx;
          Out_Valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          Out_Last  <= 1'b0;
          r_csum    <= r_csum + SR_DATA;
`else
          Out_Last  <= (r_idx == C_LAST_IDX);
`endif
          r_state   <= S_SEND;
        end

        S_SEND: begin
          if (w_hs) begin
            if (r_idx == C_LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Valid stays high: the checksum word follows with no bubble.
              Out_Data  <= r_csum;
              Out_Idx   <= '0;
              Out_Last  <= 1'b1;
              r_state   <= S_CSUM;
`else
              Out_Valid <= 1'b0;
              Out_Last  <= 1'b0;
              Done      <= 1'b1;
              r_state   <= S_DONE;
`endif
            end else begin
              Out_Valid <= 1'b0;
              Out_Last  <= 1'b0;
              r_idx     <= r_idx + 1'b1;
              r_state   <= S_ADDR;
            end
          end
        end

`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (w_hs) begin
            Out_Valid <= 1'b0;
            Out_Last  <= 1'b0;
            Done      <= 1'b1;
            r_state   <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_dump                                                 |
// | Purpose  : Self-checking bench for regfile_dump (scoreboard of words).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_dump;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int TAIL = 1;
`else
  localparam int TAIL = 0;
`endif

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Out_Ready = 1'b1;
  logic [2:0]  SR;
  logic [15:0] SR_DATA;
  logic [15:0] Out_Data;
  logic [2:0]  Out_Idx;
  logic        Out_Valid, Out_Last, Busy, Done;

  logic [15:0] rf [8];
  assign SR_DATA = rf[SR];

  typedef struct {
    logic [15:0] d;
    logic [2:0]  idx;
    logic        last;
    int          c;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  word_t stall_q[$];
  int    done_q[$];
  int    exp_done;
  int    k;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  bit    timed_out;

  regfile_dump #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .SR(SR), .SR_DATA(SR_DATA),
    .Out_Data(Out_Data), .Out_Idx(Out_Idx), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out_Last(Out_Last), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  task automatic preload_pattern();
    for (int i = 0; i < 7; i++) rf[i] = 16'(16'h1111 * (i + 1));
    rf[7] = 16'hFFFF;
  endtask

  // Start sampled at the edge that makes cyc == k; returns at that cycle's negedge.
  task automatic pulse_start();
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    k = cyc;
  endtask

  // Model: word i first valid at cyc k+1+2i, later words shifted by any stall.
  function automatic void push_expected(int stall_word, int stall_len);
    word_t       w;
    logic [15:0] sum;
    int          shift;
    sum   = '0;
    shift = (stall_word >= 0) ? stall_len : 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      w.d    = rf[i];
      w.idx  = 3'(i);
      w.last = (TAIL == 0) && (i == 7);
      w.c    = k + 1 + 2 * i + ((stall_word >= 0 && i > stall_word) ? stall_len : 0);
      sum    = sum + rf[i];
      exp_q.push_back(w);
    end
    if (TAIL == 1) begin
      w.d    = sum;
      w.idx  = 3'd0;
      w.last = 1'b1;
      w.c    = k + 16 + shift;
      exp_q.push_back(w);
    end
    exp_done = k + 16 + TAIL + shift;
  endfunction

  // Drives Out_Ready/Start/regfile writes per cycle and records what the DUT emits.
  task automatic collect(input int stall_word, input int stall_len, input bit stop_in_stall,
                         input int start_cyc, input int wr_cyc, input logic [15:0] wr_val);
    word_t w;
    int    nword, scnt, fv;
    bit    pend;
    obs_q.delete();
    stall_q.delete();
    done_q.delete();
    timed_out = 1'b0;
    nword = 0; scnt = 0; fv = 0; pend = 1'b0;
    for (int t = 0; t < 80; t++) begin
      Start = (cyc == start_cyc);
      if (cyc == wr_cyc) rf[5] = wr_val;
      if (Done) begin
        done_q.push_back(cyc);
        return;
      end
      if (Out_Valid) begin
        if (!pend) begin
          pend = 1'b1;
          fv   = cyc;
          scnt = 0;
        end
        w.d = Out_Data; w.idx = Out_Idx; w.last = Out_Last; w.c = fv;
        if (nword == stall_word && scnt < stall_len) begin
          Out_Ready = 1'b0;
          stall_q.push_back(w);
          scnt++;
          if (stop_in_stall && scnt == stall_len) return;
        end else begin
          Out_Ready = 1'b1;
          obs_q.push_back(w);
          nword++;
          pend = 1'b0;
        end
      end else begin
        Out_Ready = 1'b1;
      end
      @(negedge CLK);
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Start = 1'b0;
    Out_Ready = 1'b1;
    preload_pattern();
    repeat (3) @(negedge CLK);
    n_tests++;
    if ({Out_Data, Out_Idx, SR} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_data: Out_Data=%h Out_Idx=%0d SR=%0d, expected all 0", Out_Data, Out_Idx, SR);
    end
    n_tests++;
    if ({Out_Valid, Out_Last} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_handshake: Out_Valid=%b Out_Last=%b, expected 0 0", Out_Valid, Out_Last);
    end
    n_tests++;
    if ({Busy, Done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_status: Busy=%b Done=%b, expected 0 0", Busy, Done);
    end
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic_dump();
    word_t e, o;
    preload_pattern();
    pulse_start();
    n_tests++;
    if (Busy !== 1'b1 || Out_Valid !== 1'b0 || SR !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_addr_cycle: Busy=%b Out_Valid=%b SR=%0d, expected 1 0 0", Busy, Out_Valid, SR);
    end
    push_expected(-1, 0);
    collect(-1, 0, 1'b0, -1, -1, 16'h0);
    n_tests++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL basic_timeout: no Done within cycle budget");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL basic_word idx%0d: missing, expected d=%h", e.idx, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || o.idx !== e.idx || o.last !== e.last || o.c !== e.c) begin
          n_fail++;
          $display("FAIL basic_word: got d=%h idx=%0d last=%b cyc=%0d, expected d=%h idx=%0d last=%b cyc=%0d",
                   o.d, o.idx, o.last, o.c - k, e.d, e.idx, e.last, e.c - k);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0 || done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != exp_done)) begin
      n_fail++;
      $display("FAIL basic_done: extra_words=%0d dones=%0d done_cyc=%0d, expected 0 1 %0d",
               obs_q.size(), done_q.size(), (done_q.size() > 0) ? done_q[0] - k : -1, exp_done - k);
    end
    @(negedge CLK);
    n_tests++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_done: Busy=%b Done=%b, expected 0 0", Busy, Done);
    end
  endtask

  task automatic test_stall();
    word_t e, o;
    bit    bad;
    preload_pattern();
    pulse_start();
    push_expected(2, 3);
    collect(2, 3, 1'b0, -1, -1, 16'h0);
    n_tests++;
    bad = (stall_q.size() != 3);
    foreach (stall_q[i]) if (stall_q[i].d !== 16'h3333 || stall_q[i].idx !== 3'd2) bad = 1'b1;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_hold: %0d stall samples, first d=%h idx=%0d, expected 3 x d=3333 idx=2",
               stall_q.size(), (stall_q.size() > 0) ? stall_q[0].d : 16'hxxxx,
               (stall_q.size() > 0) ? stall_q[0].idx : 3'bxxx);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL stall_word idx%0d: missing, expected d=%h", e.idx, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || o.idx !== e.idx || o.last !== e.last || o.c !== e.c) begin
          n_fail++;
          $display("FAIL stall_word: got d=%h idx=%0d last=%b cyc=%0d, expected d=%h idx=%0d last=%b cyc=%0d",
                   o.d, o.idx, o.last, o.c - k, e.d, e.idx, e.last, e.c - k);
        end
      end
    end
    n_tests++;
    if (timed_out || done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != exp_done)) begin
      n_fail++;
      $display("FAIL stall_done: timeout=%b dones=%0d done_cyc=%0d, expected 0 1 %0d",
               timed_out, done_q.size(), (done_q.size() > 0) ? done_q[0] - k : -1, exp_done - k);
    end
    @(negedge CLK);
  endtask

  task automatic test_restart_ignored();
    bit quiet;
    preload_pattern();
    pulse_start();
    push_expected(-1, 0);
    collect(-1, 0, 1'b0, k + 5, -1, 16'h0);
    Start = 1'b0;
    n_tests++;
    if (timed_out || obs_q.size() != 8 + TAIL || done_q.size() != 1 || done_q[0] != exp_done) begin
      n_fail++;
      $display("FAIL restart_count: words=%0d dones=%0d timeout=%b, expected %0d 1 0",
               obs_q.size(), done_q.size(), timed_out, 8 + TAIL);
    end
    quiet = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (Out_Valid !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL restart_quiet: activity after Done (Out_Valid=%b Done=%b Busy=%b), expected none",
               Out_Valid, Done, Busy);
    end
  endtask

  task automatic test_reset_mid_stall();
    bit quiet;
    preload_pattern();
    pulse_start();
    collect(4, 2, 1'b1, -1, -1, 16'h0);
    n_tests++;
    if (stall_q.size() != 2 || stall_q[1].d !== 16'h5555 || stall_q[1].idx !== 3'd4) begin
      n_fail++;
      $display("FAIL rstmid_stalled: samples=%0d, expected 2 with d=5555 idx=4", stall_q.size());
    end
    Reset = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({Out_Data, Out_Idx, SR, Out_Valid, Out_Last, Busy, Done} !== 26'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: d=%h idx=%0d SR=%0d v=%b l=%b busy=%b done=%b, expected all 0",
               Out_Data, Out_Idx, SR, Out_Valid, Out_Last, Busy, Done);
    end
    Reset = 1'b1;
    Out_Ready = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (Done !== 1'b0 || Out_Valid !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL rstmid_abandon: Done or Out_Valid seen after reset, expected none");
    end
    pulse_start();
    push_expected(-1, 0);
    collect(-1, 0, 1'b0, -1, -1, 16'h0);
    n_tests++;
    if (timed_out || obs_q.size() != 8 + TAIL || obs_q[0].idx !== 3'd0 || obs_q[0].d !== exp_q[0].d
        || obs_q[0].c != exp_q[0].c || done_q.size() != 1) begin
      n_fail++;
      $display("FAIL rstmid_redump: words=%0d first idx=%0d d=%h, expected %0d words from idx 0 d=%h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].idx : 3'bxxx,
               (obs_q.size() > 0) ? obs_q[0].d : 16'hxxxx, 8 + TAIL, exp_q[0].d);
    end
    @(negedge CLK);
  endtask

  task automatic test_write_during_dump();
    word_t e, o;
    preload_pattern();
    pulse_start();
    push_expected(-1, 0);
    // The write lands before R5 is addressed, so word 5 (and the sum) see the new value.
    exp_q[5].d = 16'hBEEF;
    if (TAIL == 1) exp_q[8].d = exp_q[8].d - rf[5] + 16'hBEEF;
    collect(-1, 0, 1'b0, -1, k + 4, 16'hBEEF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_word idx%0d: missing, expected d=%h", e.idx, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || o.idx !== e.idx || o.last !== e.last || o.c !== e.c) begin
          n_fail++;
          $display("FAIL write_word: got d=%h idx=%0d last=%b cyc=%0d, expected d=%h idx=%0d last=%b cyc=%0d",
                   o.d, o.idx, o.last, o.c - k, e.d, e.idx, e.last, e.c - k);
        end
      end
    end
    @(negedge CLK);
  endtask

`ifdef REGFILE_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    rf[0] = 16'h8000; rf[1] = 16'h8000;
    for (int i = 2; i < 8; i++) rf[i] = 16'(i - 1);
    pulse_start();
    collect(-1, 0, 1'b0, -1, -1, 16'h0);
    n_tests++;
    if (obs_q.size() != 9 || obs_q[8].d !== 16'h0015 || obs_q[8].idx !== 3'd0
        || obs_q[8].last !== 1'b1 || obs_q[7].last !== 1'b0 || obs_q[8].c != k + 16) begin
      n_fail++;
      $display("FAIL csum_word: words=%0d last d=%h idx=%0d l=%b, expected 9 with d=0015 idx=0 l=1 at %0d",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1].d : 16'hxxxx,
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1].idx : 3'bxxx,
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1].last : 1'bx, 17);
    end
    n_tests++;
    if (timed_out || done_q.size() != 1 || done_q[0] != k + 17) begin
      n_fail++;
      $display("FAIL csum_done: timeout=%b dones=%0d, expected Done at cycle k+18", timed_out, done_q.size());
    end
    @(negedge CLK);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_dump();
    test_stall();
    test_restart_ignored();
    test_reset_mid_stall();
    test_write_during_dump();
`ifdef REGFILE_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_dump.md
# regfile_dump

Read-side companion to the 8×16 general-purpose register file. On a start pulse it walks source-register addresses 0–7 and reads each register through one read port (select out, data in). It streams each value out as a tagged word over a valid/ready handshake, for debug display, hex-readout or host upload logic. It never writes the register file; it only sequences its read port.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, registers dumped per run, indices 0..NUM_REGS-1
- ADDR_W, 3, register select width; NUM_REGS ≤ 2^ADDR_W

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset; one clock, synchronous active-low reset
- Start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- SR  out  ADDR_W  register select driven to the register file read port
- SR_DATA  in  DATA_W  combinational read data returned for SR
- Out_Data  out  DATA_W  streamed register value, or checksum
- Out_Idx  out  ADDR_W  register index of Out_Data; 0 for the checksum word
- Out_Valid  out  1  Out_Data/Out_Idx/Out_Last valid
- Out_Ready  in  1  consumer accepts the word when Out_Valid & Out_Ready at a rising edge
- Out_Last  out  1  marks the final word of the dump
- Busy  out  1  high from the cycle after Start is accepted until DONE completes
- Done  out  1  one-cycle pulse after the final word is accepted

## Operation
- FSM states: IDLE, ADDR, SEND, CSUM (macro only), DONE.
- IDLE: Busy=0. If Start=1, then idx←0 and the FSM goes to ADDR.
- ADDR:
  - Drive SR=idx.
  - At the clock edge, capture SR_DATA into the data register, set Out_Idx=idx, and go to SEND.
- SEND:
  - Out_Valid=1.
  - Out_Data, Out_Idx and Out_Last are held stable until handshake.
  - On handshake with idx<NUM_REGS-1: idx←idx+1, go to ADDR.
  - On handshake with idx=NUM_REGS-1: go to CSUM if enabled, else DONE.
- CSUM:
  - Out_Valid=1, Out_Idx=0, Out_Last=1, Out_Data=checksum.
  - Data is held until handshake, then the FSM goes to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Out_Last is 1 only on the final word: index NUM_REGS-1 without the macro, the checksum word with it.
- SR holds its last value outside ADDR; it is only meaningful in ADDR.
- Start while Busy=1 is ignored, with no queuing.
- Register-file writes during a dump are allowed. Each word reflects the register value at its own ADDR cycle.
- Reset=0 at any edge, including mid-dump or mid-stall:
  - FSM returns to IDLE; idx, the data register and the checksum are cleared to 0.
  - A partially sent dump is abandoned, with no Done.

## Timing
- Reset values: SR=0, Out_Data=0, Out_Idx=0, Out_Valid=0, Out_Last=0, Busy=0, Done=0.
- Start high at edge k means:
  - ADDR during cycle k+1, with Busy=1 from cycle k+1.
  - Word 0 has Out_Valid=1 in cycle k+2.
- Back-to-back with Out_Ready held at 1:
  - Word i is valid in cycle k+2+2i; word 7 is valid at k+16.
  - Done at k+17 without the macro, or k+18 with it (checksum valid at k+17).
- Each cycle of Out_Ready=0 in SEND or CSUM extends the dump by one cycle.
- Out_Valid never deasserts before handshake.
- Busy falls in the cycle after Done, with state IDLE. A new Start is accepted in that cycle.

## Configuration
- REGFILE_DUMP_CHECKSUM_EN defined:
  - Checksum is the sum of all NUM_REGS captured values, mod 2^DATA_W, accumulated at each ADDR capture and cleared at Start acceptance.
  - It is sent as one extra word after the last register.
- Not defined: CSUM state and accumulator are absent; exactly NUM_REGS words per dump.

## Test plan
- Registers preloaded 0x1111·(i+1) for i=0..6 and R7=0xFFFF, Out_Ready=1, Start pulse -> words idx 0..7 with matching values at cycles k+2,k+4,…,k+16, Out_Last only on idx 7, Done at k+17.
- Same dump with Out_Ready low 3 cycles on word 2 -> Out_Data=0x3333, Out_Idx=2 held stable throughout the stall, all later timing shifted by 3.
- Start re-pulsed while Busy=1 -> ignored; exactly 8 words and one Done.
- Reset=0 while word 4 is stalled -> next cycle all outputs 0 and state IDLE; a later Start dumps from idx 0.
- REGFILE_DUMP_CHECKSUM_EN with R0..R7 = 0x8000,0x8000,1,2,3,4,5,6 -> 9th word 0x0015 (sum 0x10015 mod 2^16), Out_Idx=0, Out_Last=1, Done at k+18.
- Register-file write to R5=0xBEEF at cycle k+5, before R5's ADDR cycle at k+11 -> word 5 = 0xBEEF.
